regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the RV64 datapath: NUM_RD combinational read ports, one write port.
//  Register 0 is hardwired to zero; optional same-cycle write-to-read bypass.
//  Adds a per-register busy scoreboard: set at instruction issue, cleared at writeback.
//  Lets the pipeline detect RAW hazards without a separate hazard unit.
// PARAMETERS
//  XLEN      64  data width in bits
//  DEPTH     32  number of architectural registers (power of 2, >=2)
//  NUM_RD    2   number of read ports (1..4)
//  BYPASS    1   1 = read port returns wr_data when reading the register being written
//  INIT_A    10  index of first register with a non-zero reset value
//  INIT_A_V  10  reset value of register INIT_A
//  INIT_B    21  index of second register with a non-zero reset value
//  INIT_B_V  9   reset value of register INIT_B
//  ADDR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)  (derived localparams)
// PORTS
//  clk          in   1              clock; all state updates on rising edge
//  reset        in   1              reset, asynchronous, active-high
//  wr_en        in   1              writeback valid
//  wr_addr      in   ADDR_W         writeback register index
//  wr_data      in   XLEN           writeback data
//  rd_addr      in   NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*XLEN    packed read data, same packing
//  rd_busy      out  NUM_RD         port i source register has a pending write
//  issue_en     in   1              instruction issued that will write issue_rd
//  issue_rd     in   ADDR_W         destination register of the issued instruction
//  flush        in   1              pipeline flush: discard all pending-write marks
//  busy_mask    out  DEPTH          current scoreboard, bit r = register r pending
//  pending_cnt  out  CNT_W          population count of busy_mask (registered)
// BEHAVIOUR
//  Reset (async): all registers 0 except reg[INIT_A]=INIT_A_V and reg[INIT_B]=INIT_B_V.
//   busy_mask=0, pending_cnt=0. rd_data and rd_busy follow combinationally from the reset state.
//  Write: on posedge, if wr_en && wr_addr!=0 then reg[wr_addr]<=wr_data. Writes to reg 0 are ignored.
//  Read (combinational, 0-cycle):
//   rd_addr[i]==0                      -> 0
//   BYPASS && wr_en && wr_addr==rd_addr[i] -> wr_data
//   otherwise                          -> reg[rd_addr[i]]
//  Scoreboard next-state, evaluated per bit r, priority top-down:
//   flush                              -> busy[r]=0 (flush does not block the write port)
//   issue_en && issue_rd==r && r!=0    -> busy[r]=1 (new producer wins over same-cycle writeback)
//   wr_en && wr_addr==r                -> busy[r]=0
//   otherwise                          -> hold
//  busy[0] is constant 0.
//  rd_busy[i] = busy[rd_addr[i]] & ~(BYPASS & wr_en & wr_addr==rd_addr[i]).
//   Data being written this cycle counts as ready only when bypass is enabled.
//  pending_cnt: registered popcount of the next-state busy vector; always equals popcount(busy_mask).
//   Maximum value DEPTH-1; no overflow possible.
//  Writeback to a non-busy register is legal: data is written, busy is unchanged.
//  Reset asserted mid-operation overrides everything: register contents and scoreboard return to reset values.
// STRUCTURE
//  rv_pkg gets:
//   - XLEN and REG_ADDR_W constants
//   - a function unpack_addr(vec, i) shared with the decode stage
//  Sub-module regfile_sb_ctrl holds busy_mask and pending_cnt (issue/writeback/flush logic).
//  The storage array and read muxes stay in the top module.
// TESTING
//  1. Assert reset, release -> reg10 reads 10, reg21 reads 9, all others 0; busy_mask=0, pending_cnt=0.
//  2. wr_en with wr_addr=0, wr_data=0xFFFF -> rd_addr=0 reads 0 next cycle; busy_mask[0] stays 0.
//  3. BYPASS=1, wr_en wr_addr=5 wr_data=0x1234, rd_addr[0]=5 in the same cycle -> rd_data[0]=0x1234 that cycle.
//     Same stimulus with BYPASS=0 -> rd_data[0]=old value.
//  4. issue_rd=7 -> busy_mask[7]=1, pending_cnt=1, rd_busy=1 for readers of reg 7.
//     Then wr_en wr_addr=7 -> busy clears and pending_cnt=0 on the following edge.
//  5. busy[7]=1, same-cycle issue_rd=7 and wr_addr=7 -> busy[7] stays 1, pending_cnt unchanged, reg7 updated.
//  6. Mark regs 3, 4 and 9 busy, then flush together with issue_rd=12 -> busy_mask=0, pending_cnt=0.
//     Reset pulse mid-sequence -> reset values restored asynchronously.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared RV64 datapath constants, scoreboard op encoding and the packed read-address
// unpack helper used by the register file and the decode stage.
package regfile_scoreboard_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;

    // Widest packed address vector the helper accepts: 4 ports x 16-bit indices.
    localparam int unsigned MAX_RD     = 4;
    localparam int unsigned MAX_AW     = 16;
    localparam int unsigned ADDR_VEC_W = MAX_RD * MAX_AW;

    typedef enum logic [1:0] {
        SB_HOLD  = 2'd0,
        SB_SET   = 2'd1,
        SB_CLEAR = 2'd2
    } sb_op_e;

    // Extract index i of width aw from a packed address vector.
    function automatic int unsigned unpack_addr(input logic [ADDR_VEC_W-1:0] vec,
                                                input int unsigned i,
                                                input int unsigned aw);
        int unsigned a;
        a = 0;
        for (int unsigned b = 0; b < MAX_AW; b++) begin
            if (b < aw && vec[i*aw + b]) begin
                a = a | (32'd1 << b);
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read/write/issue bus between the pipeline and the register file scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN   = regfile_scoreboard_pkg::XLEN,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_rd;
    logic                     flush;
    logic [DEPTH-1:0]         busy_mask;
    logic [CNT_W-1:0]         pending_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        input  rd_data, rd_busy, busy_mask, pending_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        output rd_data, rd_busy, busy_mask, pending_cnt
    );

endinterface

// File: rtl/regfile_sb_ctrl.sv
// Per-register busy scoreboard: set on issue, cleared on writeback or flush,
// with a registered population count of the pending marks.
module regfile_sb_ctrl
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic [DEPTH-1:0]  busy_mask_o,
    output logic [CNT_W-1:0]  pending_cnt_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sb_op_e           op;

    // Issue beats writeback on the same register; flush beats both.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        op     = SB_HOLD;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (flush_i) begin
                op = SB_CLEAR;
            end else if (issue_en_i && issue_rd_i == ADDR_W'(r) && r != 0) begin
                op = SB_SET;
            end else if (wr_en_i && wr_addr_i == ADDR_W'(r)) begin
                op = SB_CLEAR;
            end else begin
                op = SB_HOLD;
            end
            case (op)
                SB_SET:   busy_d[r] = 1'b1;
                SB_CLEAR: busy_d[r] = 1'b0;
                default:  busy_d[r] = busy_q[r];
            endcase
        end
        busy_d[0] = 1'b0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_mask_o   = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired zero register, optional write-to-read
// bypass, and an attached busy scoreboard for RAW hazard detection.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned     XLEN     = regfile_scoreboard_pkg::XLEN,
    parameter int unsigned     DEPTH    = 32,
    parameter int unsigned     NUM_RD   = 2,
    parameter bit              BYPASS   = 1'b1,
    parameter int unsigned     INIT_A   = 10,
    parameter longint unsigned INIT_A_V = 10,
    parameter int unsigned     INIT_B   = 21,
    parameter longint unsigned INIT_B_V = 9
) (
    input  logic               clk,
    input  logic               reset,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [XLEN-1:0]       mem_q [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [CNT_W-1:0]      pending_cnt;
    logic [ADDR_VEC_W-1:0] addr_vec;
    logic [ADDR_W-1:0]     ra  [NUM_RD];
    logic                  hit [NUM_RD];
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]     rd_busy;

    function automatic logic [XLEN-1:0] reset_val(input int unsigned r);
        if (r != 0 && r == INIT_A) return XLEN'(INIT_A_V);
        if (r != 0 && r == INIT_B) return XLEN'(INIT_B_V);
        return '0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= reset_val(r);
            end
        end else if (bus.wr_en && bus.wr_addr != '0) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        addr_vec = '0;
        addr_vec[NUM_RD*ADDR_W-1:0] = bus.rd_addr;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra[i]  = ADDR_W'(unpack_addr(addr_vec, i, ADDR_W));
            hit[i] = BYPASS && bus.wr_en && bus.wr_addr == ra[i];
            if (ra[i] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (hit[i]) begin
                rd_data[i*XLEN +: XLEN] = bus.wr_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = mem_q[ra[i]];
            end
            rd_busy[i] = busy[ra[i]] & ~hit[i];
        end
    end

    regfile_sb_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (bus.flush),
        .issue_en_i    (bus.issue_en),
        .issue_rd_i    (bus.issue_rd),
        .wr_en_i       (bus.wr_en),
        .wr_addr_i     (bus.wr_addr),
        .busy_mask_o   (busy),
        .pending_cnt_o (pending_cnt)
    );

    assign bus.rd_data     = rd_data;
    assign bus.rd_busy     = rd_busy;
    assign bus.busy_mask   = busy;
    assign bus.pending_cnt = pending_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypass and a non-bypass instance share stimulus
// and are checked against an array/rule-level reference model.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(64), .DEPTH(32), .NUM_RD(2)) bus0 ();
    regfile_scoreboard_if #(.XLEN(64), .DEPTH(32), .NUM_RD(2)) bus1 ();

    regfile_scoreboard #(.XLEN(64), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b1)) dut0 (
        .clk (clk), .reset (reset), .bus (bus0.slave)
    );
    regfile_scoreboard #(.XLEN(64), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b0)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] m_reg  [32];
    bit          m_busy [32];

    logic [63:0] cap_rd0, cap_rd1, cap_nb0;
    logic [1:0]  cap_busy;
    logic [31:0] cap_mask;
    logic [5:0]  cap_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  r0, r1;
        logic        ie;
        logic [4:0]  ir;
        logic        fl;
        logic [63:0] e_rd0, e_rd1, e_nb0;
        logic [1:0]  e_busy;
        logic [31:0] e_mask;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = (r == 10) ? 64'd10 : (r == 21) ? 64'd9 : 64'd0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a, input bit byp,
                                           input logic we, input logic [4:0] wa,
                                           input logic [63:0] wd);
        if (a == 0) return 64'd0;
        if (byp && we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a, input bit byp,
                                     input logic we, input logic [4:0] wa);
        return m_busy[a] && !(byp && we && wa == a);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = m_busy[r];
        return m;
    endfunction

    function automatic logic [5:0] m_count();
        int n = 0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
        return 6'(n);
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic ie, input logic [4:0] ir, input logic fl);
        bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.rd_addr = {r1, r0};
        bus0.issue_en = ie; bus0.issue_rd = ir; bus0.flush = fl;
        bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd; bus1.rd_addr = {r1, r0};
        bus1.issue_en = ie; bus1.issue_rd = ir; bus1.flush = fl;
    endtask

    // One clock: drive, check the combinational reads, clock, check the scoreboard.
    task automatic step(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic ie, input logic [4:0] ir, input logic fl);
        drive(we, wa, wd, r0, r1, ie, ir, fl);
        #2;
        cap_rd0  = bus0.rd_data[63:0];
        cap_rd1  = bus0.rd_data[127:64];
        cap_nb0  = bus1.rd_data[63:0];
        cap_busy = bus0.rd_busy;
        chk("rd0_byp",  cap_rd0, m_read(r0, 1, we, wa, wd));
        chk("rd1_byp",  cap_rd1, m_read(r1, 1, we, wa, wd));
        chk("rd0_nobyp", cap_nb0, m_read(r0, 0, we, wa, wd));
        chk("rd1_nobyp", bus1.rd_data[127:64], m_read(r1, 0, we, wa, wd));
        chk("rdbusy_byp", {62'd0, cap_busy},
            {62'd0, m_rbusy(r1, 1, we, wa), m_rbusy(r0, 1, we, wa)});
        chk("rdbusy_nobyp", {62'd0, bus1.rd_busy},
            {62'd0, m_rbusy(r1, 0, we, wa), m_rbusy(r0, 0, we, wa)});
        @(posedge clk);
        for (int r = 1; r < 32; r++) begin
            if (fl) m_busy[r] = 1'b0;
            else if (ie && ir == r) m_busy[r] = 1'b1;
            else if (we && wa == r) m_busy[r] = 1'b0;
        end
        if (we && wa != 0) m_reg[wa] = wd;
        #1;
        cap_mask = bus0.busy_mask;
        cap_cnt  = bus0.pending_cnt;
        chk("busy_mask", {32'd0, cap_mask}, {32'd0, m_mask()});
        chk("pending_cnt", {58'd0, cap_cnt}, {58'd0, m_count()});
        chk("busy_mask_nb", {32'd0, bus1.busy_mask}, {32'd0, m_mask()});
        chk("pending_cnt_nb", {58'd0, bus1.pending_cnt}, {58'd0, m_count()});
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        step(0, 0, 0, r0, r1, 0, 0, 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 64'hFFFF, 0, 10, 0, 0, 0, 64'd0, 64'd10, 64'd0, 2'b00, 32'h0, 6'd0};
        tbl[1] = '{0, 0, 64'h0, 0, 21, 0, 0, 0, 64'd0, 64'd9, 64'd0, 2'b00, 32'h0, 6'd0};
        tbl[2] = '{1, 5, 64'h1234, 5, 10, 0, 0, 0, 64'h1234, 64'd10, 64'd0, 2'b00, 32'h0, 6'd0};
        tbl[3] = '{0, 0, 64'h0, 7, 5, 1, 7, 0, 64'd0, 64'h1234, 64'd0, 2'b00, 32'h80, 6'd1};
        tbl[4] = '{0, 0, 64'h0, 7, 5, 0, 0, 0, 64'd0, 64'h1234, 64'd0, 2'b01, 32'h80, 6'd1};
        tbl[5] = '{1, 7, 64'h77, 7, 7, 0, 0, 0, 64'h77, 64'h77, 64'd0, 2'b00, 32'h0, 6'd0};
        tbl[6] = '{0, 0, 64'h0, 7, 0, 1, 7, 0, 64'h77, 64'd0, 64'h77, 2'b00, 32'h80, 6'd1};
        tbl[7] = '{1, 7, 64'hAB, 7, 3, 1, 7, 0, 64'hAB, 64'd0, 64'h77, 2'b00, 32'h80, 6'd1};
        tbl[8] = '{0, 0, 64'h0, 7, 7, 0, 0, 0, 64'hAB, 64'hAB, 64'hAB, 2'b11, 32'h80, 6'd1};
        tbl[9] = '{1, 9, 64'h55, 9, 7, 0, 0, 0, 64'h55, 64'hAB, 64'd0, 2'b10, 32'h80, 6'd1};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_mask", {32'd0, bus0.busy_mask}, 64'd0);
        chk("rst_cnt", {58'd0, bus0.pending_cnt}, 64'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 32; k++) begin
            idle(5'(k), 5'(31 - k));
            chk("rst_val", cap_rd0, (k == 10) ? 64'd10 : (k == 21) ? 64'd9 : 64'd0);
        end

        for (int t = 0; t < 10; t++) begin
            step(tbl[t].we, tbl[t].wa, tbl[t].wd, tbl[t].r0, tbl[t].r1,
                 tbl[t].ie, tbl[t].ir, tbl[t].fl);
            chk($sformatf("tbl%0d_rd0", t), cap_rd0, tbl[t].e_rd0);
            chk($sformatf("tbl%0d_rd1", t), cap_rd1, tbl[t].e_rd1);
            chk($sformatf("tbl%0d_nb0", t), cap_nb0, tbl[t].e_nb0);
            chk($sformatf("tbl%0d_busy", t), {62'd0, cap_busy}, {62'd0, tbl[t].e_busy});
            chk($sformatf("tbl%0d_mask", t), {32'd0, cap_mask}, {32'd0, tbl[t].e_mask});
            chk($sformatf("tbl%0d_cnt", t), {58'd0, cap_cnt}, {58'd0, tbl[t].e_cnt});
        end

        // Flush with a concurrent issue and an unblocked writeback.
        step(0, 0, 0, 3, 4, 1, 3, 0);
        step(0, 0, 0, 3, 4, 1, 4, 0);
        step(0, 0, 0, 3, 4, 1, 9, 0);
        chk("multi_mask", {32'd0, cap_mask}, 64'h298);
        chk("multi_cnt", {58'd0, cap_cnt}, 64'd4);
        step(1, 2, 64'h22, 3, 9, 1, 12, 1);
        chk("flush_mask", {32'd0, cap_mask}, 64'd0);
        chk("flush_cnt", {58'd0, cap_cnt}, 64'd0);
        idle(2, 12);
        chk("flush_wr", cap_rd0, 64'h22);

        // Asynchronous reset in the middle of activity.
        step(0, 0, 0, 3, 4, 1, 3, 0);
        step(1, 10, 64'hDEAD, 3, 10, 1, 6, 0);
        drive(0, 0, 0, 10, 2, 0, 0, 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_mask", {32'd0, bus0.busy_mask}, 64'd0);
        chk("mid_rst_cnt", {58'd0, bus0.pending_cnt}, 64'd0);
        chk("mid_rst_r10", bus0.rd_data[63:0], 64'd10);
        chk("mid_rst_r2", bus0.rd_data[127:64], 64'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                 5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), 5'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
